// File: rtl/clk_div_prog.sv
// Programmable clock divider: produces either a ceil(N/2)-high divided clock or a
// one-clk pulse every N clocks, with safe divisor reloads that only take effect at a period wrap.
module clk_div_prog #(
  parameter int W       = 16,
  parameter int RST_DIV = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [W-1:0] div_val,
  input  logic         div_load,
  output logic         div_busy,
  output logic         div_err,
  output logic         clk_div,
  output logic         div_pulse,
  output logic         running
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]   state, state_nx;
  logic [W-1:0] cnt, cnt_nx;
  logic [W-1:0] n_q, n_nx;
  logic [W-1:0] pend_q;
  logic         mode_q, mode_nx;
  logic         last, wrap, apply, load_ok, active_nx;
  logic [W-1:0] h_nx;

  assign last    = (cnt == n_q - W'(1));
  assign wrap    = (state != IDLE) && last;
  assign apply   = div_busy && ((state == IDLE) || wrap);
  assign load_ok = div_load && (div_val > W'(1));

  // RUN and DRAIN advance identically; en only decides where a finished period goes next
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mode_nx  = mode_q;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (en) begin
          state_nx = RUN;
          mode_nx  = mode;
        end
      end
      RUN, DRAIN: begin
        if (last) begin
          cnt_nx   = '0;
          state_nx = en ? RUN : IDLE;
        end else begin
          cnt_nx   = cnt + W'(1);
          state_nx = en ? RUN : DRAIN;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from next-cycle state so they line up with cnt
  always_comb begin
    n_nx      = apply ? pend_q : n_q;
    h_nx      = (n_nx >> 1) + {{(W-1){1'b0}}, n_nx[0]};
    active_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      n_q       <= W'(RST_DIV);
      pend_q    <= '0;
      mode_q    <= 1'b0;
      div_busy  <= 1'b0;
      div_err   <= 1'b0;
      clk_div   <= 1'b0;
      div_pulse <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      n_q       <= n_nx;
      mode_q    <= mode_nx;
      div_err   <= div_load && !load_ok;
      clk_div   <= active_nx && !mode_nx && (cnt_nx < h_nx);
      div_pulse <= active_nx && mode_nx && (cnt_nx == '0);
      running   <= active_nx;
      // A load landing on the apply cycle stays pending for the next wrap
      if (load_ok) begin
        pend_q   <= div_val;
        div_busy <= 1'b1;
      end else if (apply) begin
        div_busy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning divisor and counter width in bits.
REQ-002 The block SHALL have parameter RST_DIV, default 2, meaning the divisor in effect after reset; the legal range is 2..2^W-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock (50 MHz nominal); all logic is rising-edge clocked.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: run request, level-sensitive.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 selects clock output, 1 selects pulse output; sampled only in IDLE.
REQ-007 The block SHALL have port div_val, input, W bits: new divisor N, qualified by div_load.
REQ-008 The block SHALL have port div_load, input, 1 bit: one-cycle strobe that captures div_val.
REQ-009 The block SHALL have port div_busy, output, 1 bit: a captured divisor is pending and not yet applied.
REQ-010 The block SHALL have port div_err, output, 1 bit: one-cycle pulse indicating a rejected load.
REQ-011 The block SHALL have port clk_div, output, 1 bit: divided clock, registered; valid when mode=0.
REQ-012 The block SHALL have port div_pulse, output, 1 bit: one-clk-wide pulse per period, registered; valid when mode=1.
REQ-013 The block SHALL have port running, output, 1 bit: high while in the RUN or DRAIN state.

Function
REQ-014 The block SHALL implement states IDLE, RUN and DRAIN, and SHALL keep a period counter cnt of W bits that counts 0..N-1 and wraps to 0.
REQ-015 In IDLE, cnt SHALL be 0 and clk_div, div_pulse and running SHALL all be 0.
REQ-016 On en=1 sampled in IDLE, the block SHALL enter RUN and latch mode; clk_div (mode 0) or div_pulse (mode 1) SHALL assert 1 clk after that edge.
REQ-017 In mode 0, clk_div SHALL be high while cnt < H and low while H <= cnt <= N-1, where H = ceil(N/2); even N therefore gives 50% duty and odd N gives an (N+1)/2 : (N-1)/2 high:low split.
REQ-018 In mode 1, div_pulse SHALL be high exactly while cnt = 0, i.e. once every N clks, and clk_div SHALL be held at 0.
REQ-019 On en=0 sampled in RUN, the block SHALL enter DRAIN, complete the current period through cnt=N-1, then enter IDLE; the block SHALL never truncate a period.
REQ-020 On en=1 sampled in DRAIN, the block SHALL return to RUN with no gap and no phase change.
REQ-021 A div_load with div_val >= 2 SHALL be captured into a pending register, and div_busy SHALL be 1 from the next clk.
REQ-022 A pending divisor SHALL become N at the wrap of cnt from N-1 to 0, or on the next clk if the block is in IDLE; div_busy SHALL clear in that same cycle.
REQ-023 When div_load arrives while div_busy=1, the new value SHALL overwrite the pending value (last write wins).
REQ-024 When div_load arrives together with the apply cycle, the newly loaded value SHALL remain pending and SHALL be applied at the following wrap.
REQ-025 A div_load with div_val of 0 or 1 SHALL be ignored, and div_err SHALL pulse for 1 clk; pending state and N SHALL be unchanged.
REQ-026 Changing mode outside IDLE SHALL have no effect until the next IDLE-to-RUN transition.
REQ-027 The counter SHALL be exercised up to N = 2^W-1 with no overflow; the comparisons use W-bit unsigned values.

Reset
REQ-028 While rst_n=0, regardless of clk, the block SHALL force: state IDLE, cnt 0, N = RST_DIV, pending cleared, div_busy 0, div_err 0, clk_div 0, div_pulse 0, running 0.
REQ-029 Reset asserted mid-period SHALL abort immediately with no completion of the period.
REQ-030 After rst_n is released, the block SHALL restart only on a subsequent en=1.

Verification
REQ-031 The bench SHALL cover this scenario: reset, en=1, mode 0, N=2 -> clk_div toggles every clk (25 MHz), first high 1 clk after en is sampled.
REQ-032 The bench SHALL cover this scenario: load 5, mode 0 -> clk_div pattern 1,1,1,0,0 repeating; load 4 -> pattern 1,1,0,0.
REQ-033 The bench SHALL cover this scenario: mode 1, N=10, run 100 clks -> exactly 10 div_pulse cycles, spaced 10 clks apart.
REQ-034 The bench SHALL cover this scenario: N=8 running, load 3 at cnt=2 -> div_busy high for 5 clks, then 3-clk periods from the wrap; load 6 then 9 in consecutive clks -> 9 applied.
REQ-035 The bench SHALL cover this scenario: N=6, drop en at cnt=1 -> 4 more clks of the period, then running=0; re-raise en during DRAIN -> continuous waveform.
REQ-036 The bench SHALL cover this scenario: div_val=1 load -> div_err 1-clk pulse and N unchanged; rst_n low at cnt=3 of N=7 -> all outputs 0 at once, and N=RST_DIV after release.
